inst_rom_boot: RTL

Instruction memory plus boot loader that sits directly upstream of the CPU core's instruction port. It drives `inst_o` into the core's instruction-data input, addressed by the core's instruction address and enable outputs. After reset, an FSM fills the memory from a byte-stream load port and holds the core in reset (`cpu_rst_o`) until the image is complete. A later `boot_req` reloads the image at run time.

---
 rtl/inst_rom_boot_pkg.sv | 14 +
 rtl/inst_rom_mem.sv | 17 +
 rtl/inst_rom_boot.sv | 92 +++++++++
 3 files changed

// File: rtl/inst_rom_boot_pkg.sv
// inst_rom_boot_pkg: shared widths, constants and boot FSM state encodings.
package inst_rom_boot_pkg;
  localparam int INST_W = 32;
  localparam int ADDR_W_DEF = 10;
  localparam int CNT_W_DEF = 16;
  localparam logic [INST_W-1:0] ZERO_WORD = '0;
  typedef enum logic [2:0] {
    S_LEN_HI = 3'd0,
    S_LEN_LO = 3'd1,
    S_DATA   = 3'd2,
    S_RUN    = 3'd3,
    S_ERR    = 3'd4
  } boot_st_t;
endpackage

// File: rtl/inst_rom_mem.sv
// inst_rom_mem: instruction storage, one synchronous write port and an asynchronous read port.
module inst_rom_mem
  import inst_rom_boot_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [INST_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [INST_W-1:0] rdata
);
  logic [INST_W-1:0] mem_q [2**ADDR_W];
  always_ff @(posedge clk) if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/inst_rom_boot.sv
// inst_rom_boot: instruction memory with a byte-stream boot loader that holds the core in reset until loaded.
module inst_rom_boot
  import inst_rom_boot_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic [31:0]       addr_i,
  output logic [INST_W-1:0] inst_o,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  output logic              ld_ready,
  input  logic              boot_req,
  output logic              cpu_rst_o,
  output logic              load_done,
  output logic              load_err
);
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1) << ADDR_W;
  boot_st_t          state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [1:0]        idx_q, idx_d;
  logic [23:0]       asm_q, asm_d;
  logic [CNT_W-1:0]  hdr;
  logic              acc, we;
  logic [ADDR_W-1:0] ridx;
  logic [INST_W-1:0] rdata;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= S_LEN_HI;
      cnt_q   <= '0;
      wptr_q  <= '0;
      idx_q   <= '0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
    end
  assign ld_ready = state_q == S_LEN_HI || state_q == S_LEN_LO || state_q == S_DATA;
  assign acc      = ld_valid && ld_ready;
  assign we       = acc && state_q == S_DATA && idx_q == 2'd3;
  assign hdr      = {cnt_q[CNT_W-1:8], ld_byte};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wptr_d  = wptr_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    case (state_q)
      S_LEN_HI: if (acc) begin
        cnt_d   = {{(CNT_W-8){1'b0}}, ld_byte} << 8;
        state_d = S_LEN_LO;
      end
      S_LEN_LO: if (acc) begin
        cnt_d   = hdr;
        wptr_d  = '0;
        idx_d   = '0;
        state_d = hdr == '0 ? S_RUN : hdr > DEPTH ? S_ERR : S_DATA;
      end
      S_DATA: if (acc) begin
        idx_d = idx_q + 2'd1;
        asm_d = {asm_q[15:0], ld_byte};
        if (idx_q == 2'd3) begin
          wptr_d = wptr_q + 1'b1;
          // compare in count width so a full-depth image terminates before wptr wraps
          if (CNT_W'(wptr_q) + CNT_W'(1) == cnt_q) state_d = S_RUN;
        end
      end
      S_RUN: if (boot_req) state_d = S_LEN_HI;
      default: state_d = state_q;
    endcase
  end
  assign cpu_rst_o = state_q != S_RUN;
  assign load_done = state_q == S_RUN;
  assign load_err  = state_q == S_ERR;
  assign ridx = addr_i[ADDR_W+1:2];
  inst_rom_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk  (clk),
    .we   (we),
    .waddr(wptr_q),
    .wdata({asm_q, ld_byte}),
    .raddr(ridx),
    .rdata(rdata)
  );
  assign inst_o = (ce_i && state_q == S_RUN && addr_i[31:ADDR_W+2] == '0 && CNT_W'(ridx) < cnt_q) ? rdata : ZERO_WORD;
endmodule
